axil_master: RTL

AXI4-lite initiator driving an `axi_if.master` modport from a simple single-outstanding command/response port. It issues one read or write at a time and returns the slave's response and read data. It sits between internal control logic (sequencers, CSR updaters, test engines) and AXI4-lite slave fabrics built on the same `axi_if` definition.

---
 rtl/axil_master_if.sv | 36 +++
 rtl/axil_master.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/axil_master_if.sv
// rtl/axil_master_if.sv - AXI4-lite bus interface (axi_if) shared by initiators and slaves
interface axi_if #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4
);
  logic [P_ASIZE-1:0]    awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [P_DBYTES*8-1:0] wdata;
  logic [P_DBYTES-1:0]   wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [P_ASIZE-1:0]    araddr;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [P_DBYTES*8-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arsize, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arsize, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-lite initiator behind a cmd/rsp port
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4,
  parameter int P_TMO    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [P_ASIZE-1:0]    cmd_addr,
  input  logic [P_DBYTES*8-1:0] cmd_wdata,
  input  logic [P_DBYTES-1:0]   cmd_wstrb,
  input  logic [2:0]            cmd_size,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [P_DBYTES*8-1:0] rsp_rdata,
  output logic                  rsp_tmo,
  axi_if.master                 m
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t state, state_d;
  logic   aw_done, w_done, aw_done_d, w_done_d;
  logic   tmo_hit, tmo_take;
  logic   cmd_take, b_take, r_take;

  assign cmd_ready = (state == IDLE);
  assign cmd_take  = cmd_valid & cmd_ready;
  assign b_take    = (state == WRESP) & m.bvalid & m.bready;
  assign r_take    = (state == RDATA) & m.rvalid & m.rready;

  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    tmo_take  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = cmd_write ? WR : RADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR: begin
        // AW and W complete independently; leave only when both are done.
        if (m.awvalid && m.awready) aw_done_d = 1'b1;
        if (m.wvalid && m.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)  state_d   = WRESP;
        else if (tmo_hit)           tmo_take  = 1'b1;
      end
      WRESP: begin
        if (b_take)       state_d  = RSP;
        else if (tmo_hit) tmo_take = 1'b1;
      end
      RADDR: begin
        if (m.arvalid && m.arready) state_d  = RDATA;
        else if (tmo_hit)           tmo_take = 1'b1;
      end
      RDATA: begin
        if (r_take)       state_d  = RSP;
        else if (tmo_hit) tmo_take = 1'b1;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_take) state_d = RSP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m.awvalid <= 1'b0;
      m.wvalid  <= 1'b0;
      m.bready  <= 1'b0;
      m.arvalid <= 1'b0;
      m.rready  <= 1'b0;
      m.awaddr  <= '0;
      m.araddr  <= '0;
      m.wdata   <= '0;
      m.wstrb   <= '0;
      m.arsize  <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_resp  <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      aw_done   <= aw_done_d;
      w_done    <= w_done_d;
      // Handshake outputs are pure functions of the next state, so they stay registered.
      m.awvalid <= (state_d == WR) && !aw_done_d;
      m.wvalid  <= (state_d == WR) && !w_done_d;
      m.bready  <= (state_d == WRESP);
      m.arvalid <= (state_d == RADDR);
      m.rready  <= (state_d == RDATA);
      rsp_valid <= (state_d == RSP);
      if (cmd_take) begin
        m.awaddr <= cmd_addr;
        m.araddr <= cmd_addr;
        m.wdata  <= cmd_wdata;
        m.wstrb  <= cmd_wstrb;
        m.arsize <= cmd_size;
      end
      if (b_take) begin
        rsp_write <= 1'b1;
        rsp_resp  <= m.bresp;
        rsp_rdata <= '0;
      end else if (r_take) begin
        rsp_write <= 1'b0;
        rsp_resp  <= m.rresp;
        rsp_rdata <= m.rdata;
      end else if (tmo_take) begin
        rsp_write <= (state == WR) || (state == WRESP);
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
      end
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = ($clog2(P_TMO + 1) > 8) ? $clog2(P_TMO + 1) : 8;
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == CW'(P_TMO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_d != state) begin
      tmo_cnt <= '0;
    end else if (state inside {WR, WRESP, RADDR, RDATA}) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tmo <= 1'b0;
    end else if (tmo_take) begin
      rsp_tmo <= 1'b1;
    end else if (b_take || r_take) begin
      rsp_tmo <= 1'b0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (P_TMO == 0);
  assign tmo_hit    = 1'b0;
  assign rsp_tmo    = 1'b0;
`endif
endmodule
